// File: rtl/rv32i_mc_controller_if.sv
// Shared instruction/data memory port between the multi-cycle controller and memory.
// The controller raises mem_req and holds the access until memory answers with mem_ready.
interface rv32i_mc_controller_if;
  logic mem_req;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, mem_write, iord, input mem_ready);
  modport slave  (input mem_req, mem_write, iord, output mem_ready);
endinterface

// File: rtl/rv32i_mc_controller.sv
// Moore-style multi-cycle control FSM for the RV32I datapath: fetch/decode/execute/mem/wb.
// A per-access watchdog traps when the shared memory port never answers.
module rv32i_mc_controller #(
  parameter int n        = 32,
  parameter int WAIT_MAX = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [n-1:0]          inst,
  input  logic                  zero,
  input  logic                  lessSigend,
  input  logic                  lessUnsigend,
  rv32i_mc_controller_if.master mem,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [3:0]            alu_ctrl,
  output logic                  instr_retired,
  output logic                  trap,
  output logic [1:0]            trap_cause
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state, state_n;
  logic [1:0] cause_q, cause_n;
  logic [7:0] wcnt, wcnt_n;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       wait_hit;
  logic       taken;
  logic       unused_inst;

  assign opcode      = inst[6:0];
  assign funct3      = inst[14:12];
  assign funct7_5    = inst[30];
  assign unused_inst = ^{inst[n-1], inst[29:15], inst[11:7]};

  // Counter already holds WAIT_MAX-1 idle cycles: this idle cycle is the last one allowed.
  assign wait_hit = (wcnt == WAIT_LAST) && !mem.mem_ready;

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lessSigend;
      3'b101:  taken = !lessSigend;
      3'b110:  taken = lessUnsigend;
      3'b111:  taken = !lessUnsigend;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      cause_q <= 2'b00;
      wcnt    <= 8'd0;
    end else begin
      state   <= state_n;
      cause_q <= cause_n;
      wcnt    <= wcnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    cause_n       = cause_q;
    wcnt_n        = 8'd0;
    mem.mem_req   = 1'b0;
    mem.mem_write = 1'b0;
    mem.iord      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_ctrl      = ALU_ADD;
    instr_retired = 1'b0;
    trap          = 1'b0;
    trap_cause    = 2'b00;
    // Reset forces every output low immediately, even mid-access.
    if (!reset) begin
      case (state)
        FETCH: begin
          mem.mem_req = 1'b1;
          alu_src_b   = 2'b10;
          if (mem.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_n  = DECODE;
          end else if (wait_hit) begin
            state_n = TRAP;
            cause_n = CAUSE_TIMEOUT;
          end else begin
            wcnt_n = wcnt + 8'd1;
          end
        end
        DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          case (opcode)
            7'b0000011, 7'b0100011: state_n = MEM_ADDR;
            7'b0110011:             state_n = EXEC_R;
            7'b0010011:             state_n = EXEC_I;
            7'b1101111:             state_n = JAL;
            7'b0110111:             state_n = LUI;
            7'b1100011: begin
              if (funct3[2:1] == 2'b01) begin
                state_n = TRAP;
                cause_n = CAUSE_ILLEGAL;
              end else begin
                state_n = BRANCH;
              end
            end
            default: begin
              state_n = TRAP;
              cause_n = CAUSE_ILLEGAL;
            end
          endcase
        end
        MEM_ADDR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          state_n   = opcode[5] ? MEM_WR : MEM_RD;
        end
        MEM_RD, MEM_WR: begin
          mem.mem_req   = 1'b1;
          mem.iord      = 1'b1;
          mem.mem_write = (state == MEM_WR);
          if (mem.mem_ready) begin
            instr_retired = (state == MEM_WR);
            state_n       = (state == MEM_WR) ? FETCH : MEM_WB;
          end else if (wait_hit) begin
            state_n = TRAP;
            cause_n = CAUSE_TIMEOUT;
          end else begin
            wcnt_n = wcnt + 8'd1;
          end
        end
        MEM_WB: begin
          reg_write     = 1'b1;
          result_src    = 2'b01;
          instr_retired = 1'b1;
          state_n       = FETCH;
        end
        EXEC_R: begin
          alu_src_a = 2'b10;
          alu_ctrl  = {funct7_5, funct3};
          state_n   = ALU_WB;
        end
        EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          // Only SRAI/SRLI use funct7[5]; elsewhere bit 30 is immediate data.
          alu_ctrl  = (funct3 == 3'b101) ? {funct7_5, funct3} : {1'b0, funct3};
          state_n   = ALU_WB;
        end
        ALU_WB: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
          state_n       = FETCH;
        end
        BRANCH: begin
          alu_src_a     = 2'b10;
          alu_ctrl      = ALU_SUB;
          pc_write      = taken;
          pc_src        = 1'b1;
          instr_retired = 1'b1;
          state_n       = FETCH;
        end
        JAL: begin
          reg_write     = 1'b1;
          result_src    = 2'b10;
          pc_write      = 1'b1;
          pc_src        = 1'b1;
          instr_retired = 1'b1;
          state_n       = FETCH;
        end
        LUI: begin
          reg_write     = 1'b1;
          result_src    = 2'b11;
          instr_retired = 1'b1;
          state_n       = FETCH;
        end
        TRAP: begin
          trap       = 1'b1;
          trap_cause = cause_q;
        end
        default: state_n = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mc_controller.sv
// Directed bench for rv32i_mc_controller: one task per scenario, hand-computed expectations.
module tb_rv32i_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst = 32'h0;
  logic        zero = 1'b0, lessSigend = 1'b0, lessUnsigend = 1'b0;
  logic        ir_write, pc_write, pc_src, reg_write, instr_retired, trap;
  logic [1:0]  result_src, alu_src_a, alu_src_b, trap_cause;
  logic [3:0]  alu_ctrl;
  int          tests_run = 0;
  int          tests_failed = 0;

  rv32i_mc_controller_if bus();

  rv32i_mc_controller #(.n(32), .WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset), .inst(inst), .zero(zero),
    .lessSigend(lessSigend), .lessUnsigend(lessUnsigend), .mem(bus),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .instr_retired(instr_retired),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h00012083;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_LUI  = 32'h123450B7;

  function automatic logic [20:0] outs();
    return {bus.mem_req, bus.mem_write, bus.iord, ir_write, pc_write, pc_src, reg_write,
            result_src, alu_src_a, alu_src_b, alu_ctrl, instr_retired, trap, trap_cause};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // Reset, fetch with immediate ready, decode; returns one tick into the third state.
  task automatic to_exec(input logic [31:0] ins);
    do_reset();
    inst = ins;
    bus.mem_ready = 1'b1;
    step();
    step();
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    tests_run++;
    if (outs() !== 21'h0) begin
      tests_failed++; $display("FAIL reset_outs: got %h want 0", outs());
    end
    step();
    tests_run++;
    if (outs() !== 21'h0) begin
      tests_failed++; $display("FAIL reset_held_outs: got %h want 0", outs());
    end
  endtask

  task automatic test_addi();
    do_reset();
    inst = I_ADDI;
    bus.mem_ready = 1'b1;
    #1;
    tests_run++;
    if ({bus.mem_req, bus.iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl}
        !== {5'b10110, 2'b00, 2'b10, 4'b0000}) begin
      tests_failed++; $display("FAIL addi_fetch: got %h", outs());
    end
    step();
    tests_run++;
    if ({bus.mem_req, ir_write, alu_src_a, alu_src_b, alu_ctrl} !== {2'b00, 2'b01, 2'b01, 4'b0000}) begin
      tests_failed++; $display("FAIL addi_decode: got %h", outs());
    end
    step();
    tests_run++;
    if ({bus.mem_req, reg_write, instr_retired, alu_src_a, alu_src_b, alu_ctrl}
        !== {3'b000, 2'b10, 2'b01, 4'b0000}) begin
      tests_failed++; $display("FAIL addi_exec_i: got %h", outs());
    end
    step();
    tests_run++;
    if ({bus.mem_req, reg_write, result_src, instr_retired} !== 5'b01001) begin
      tests_failed++; $display("FAIL addi_alu_wb: got %h", outs());
    end
    step();
    tests_run++;
    if ({bus.mem_req, bus.iord, instr_retired} !== 3'b100) begin
      tests_failed++; $display("FAIL addi_next_fetch: got %h", outs());
    end
  endtask

  task automatic test_load();
    to_exec(I_LW);
    #1;
    tests_run++;
    if ({bus.mem_req, alu_src_a, alu_src_b, alu_ctrl} !== {1'b0, 2'b10, 2'b01, 4'b0000}) begin
      tests_failed++; $display("FAIL lw_mem_addr: got %h", outs());
    end
    step();
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3);
      #1;
      tests_run++;
      if ({bus.mem_req, bus.iord, bus.mem_write, reg_write, instr_retired} !== 5'b11000) begin
        tests_failed++; $display("FAIL lw_mem_rd_%0d: got %h", i, outs());
      end
      step();
    end
    bus.mem_ready = 1'b0;
    #1;
    tests_run++;
    if ({bus.mem_req, reg_write, result_src, instr_retired} !== 5'b01011) begin
      tests_failed++; $display("FAIL lw_mem_wb: got %h", outs());
    end
  endtask

  task automatic test_branch();
    logic [31:0] bi [5] = '{32'h00209463, 32'h0020F463, 32'h00208463, 32'h0020C463, 32'h0020E463};
    logic [2:0]  fl [5] = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b000};
    logic        pw [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      to_exec(bi[i]);
      {zero, lessSigend, lessUnsigend} = fl[i];
      #1;
      tests_run++;
      if ({pc_write, pc_src, instr_retired, reg_write, alu_src_a, alu_src_b, alu_ctrl}
          !== {pw[i], 3'b110, 2'b10, 2'b00, 4'b1000}) begin
        tests_failed++; $display("FAIL branch_%0d: got %h pc_write want %b", i, outs(), pw[i]);
      end
      step();
      tests_run++;
      if ({bus.mem_req, bus.iord, pc_write} !== 3'b100) begin
        tests_failed++; $display("FAIL branch_%0d_refetch: got %h", i, outs());
      end
    end
    {zero, lessSigend, lessUnsigend} = 3'b000;
  endtask

  task automatic test_alu_ctrl();
    logic [31:0] ai [6] = '{32'h402081B3, 32'h002081B3, 32'h0020B1B3,
                            32'h4030D093, 32'h0030D093, 32'hFFF0C093};
    logic [3:0]  ac [6] = '{4'b1000, 4'b0000, 4'b0011, 4'b1101, 4'b0101, 4'b0100};
    logic [1:0]  sb [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 6; i++) begin
      to_exec(ai[i]);
      #1;
      tests_run++;
      if ({alu_ctrl, alu_src_a, alu_src_b, reg_write} !== {ac[i], 2'b10, sb[i], 1'b0}) begin
        tests_failed++; $display("FAIL alu_ctrl_%0d: got %b want %b", i, alu_ctrl, ac[i]);
      end
      step();
      tests_run++;
      if ({reg_write, result_src, instr_retired} !== 4'b1001) begin
        tests_failed++; $display("FAIL alu_wb_%0d: got %h", i, outs());
      end
    end
  endtask

  task automatic test_jal_lui();
    to_exec(I_JAL);
    #1;
    tests_run++;
    if ({reg_write, result_src, pc_write, pc_src, instr_retired} !== 6'b110111) begin
      tests_failed++; $display("FAIL jal: got %h", outs());
    end
    to_exec(I_LUI);
    #1;
    tests_run++;
    if ({reg_write, result_src, pc_write, pc_src, instr_retired} !== 6'b111001) begin
      tests_failed++; $display("FAIL lui: got %h", outs());
    end
  endtask

  task automatic test_store();
    to_exec(I_SW);
    bus.mem_ready = 1'b1;
    step();
    tests_run++;
    if ({bus.mem_req, bus.mem_write, bus.iord, instr_retired, reg_write} !== 5'b11110) begin
      tests_failed++; $display("FAIL sw_mem_wr: got %h", outs());
    end
    step();
    tests_run++;
    if ({bus.mem_req, bus.mem_write, bus.iord} !== 3'b100) begin
      tests_failed++; $display("FAIL sw_refetch: got %h", outs());
    end
  endtask

  task automatic test_watchdog_edge();
    to_exec(I_SW);
    step();
    for (int i = 0; i < 3; i++) step();
    bus.mem_ready = 1'b1;
    #1;
    tests_run++;
    if ({bus.mem_req, instr_retired, trap} !== 3'b110) begin
      tests_failed++; $display("FAIL wd_ready_at_limit: got %h", outs());
    end
    step();
    tests_run++;
    if ({bus.mem_req, bus.iord, trap} !== 3'b100) begin
      tests_failed++; $display("FAIL wd_limit_refetch: got %h", outs());
    end
  endtask

  task automatic test_timeout();
    to_exec(I_SW);
    step();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({bus.mem_req, bus.mem_write, trap} !== 3'b110) begin
        tests_failed++; $display("FAIL timeout_wait_%0d: got %h", i, outs());
      end
      step();
    end
    tests_run++;
    if ({bus.mem_req, trap, trap_cause} !== 4'b0110) begin
      tests_failed++; $display("FAIL timeout_trap: got %h want cause 10", outs());
    end
    bus.mem_ready = 1'b1;
    step();
    step();
    tests_run++;
    if ({bus.mem_req, ir_write, trap, trap_cause} !== 5'b00110) begin
      tests_failed++; $display("FAIL timeout_absorb: got %h", outs());
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ii [2] = '{32'h0000007F, 32'h0020A463};
    for (int k = 0; k < 2; k++) begin
      to_exec(ii[k]);
      #1;
      tests_run++;
      if ({bus.mem_req, trap, trap_cause} !== 4'b0101) begin
        tests_failed++; $display("FAIL illegal_%0d_trap: got %h want cause 01", k, outs());
      end
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      tests_run++;
      if ({bus.mem_req, pc_write, reg_write, ir_write, trap, trap_cause} !== 7'b0000101) begin
        tests_failed++; $display("FAIL illegal_%0d_absorb: got %h", k, outs());
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    to_exec(I_SW);
    step();
    step();
    #1;
    tests_run++;
    if ({bus.mem_req, bus.mem_write} !== 2'b11) begin
      tests_failed++; $display("FAIL rst_mid_pre: got %h", outs());
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (outs() !== 21'h0) begin
      tests_failed++; $display("FAIL rst_mid_async: got %h want 0", outs());
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({bus.mem_req, bus.mem_write, bus.iord} !== 3'b100) begin
      tests_failed++; $display("FAIL rst_mid_fetch: got %h", outs());
    end
    bus.mem_ready = 1'b1;
    step();
    tests_run++;
    if ({bus.mem_req, alu_src_a} !== 3'b001) begin
      tests_failed++; $display("FAIL rst_mid_decode: got %h", outs());
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_load();
    test_branch();
    test_alu_ctrl();
    test_jal_lui();
    test_store();
    test_watchdog_edge();
    test_timeout();
    test_illegal();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rv32i_mc_controller.md
Name: rv32i_mc_controller

Overview:
Multi-cycle sequencing controller for the RV32I datapath. It replaces the combinational single-cycle control unit with a Moore FSM. The FSM steps each instruction through fetch, decode, execute, memory and writeback over 3–5 cycles. One shared instruction/data memory port is driven through a req/ready handshake, and a per-access watchdog detects a memory that never responds.

Parameters:
- n, 32, instruction/datapath width; only 32 is supported.
- WAIT_MAX, 64, maximum cycles in one memory-access state without mem_ready before a timeout trap; legal range 1..255.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears the FSM to FETCH.
- inst  in  n  instruction register contents; valid from the DECODE state onward.
- zero  in  1  ALU result == 0.
- lessSigend  in  1  rs1 < rs2, signed.
- lessUnsigend  in  1  rs1 < rs2, unsigned.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  access is a store; qualified by mem_req.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  load the PC.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- reg_write  out  1  register file write enable.
- result_src  out  2  writeback source: 00 = ALUOut, 01 = memory data, 10 = PC (already PC+4), 11 = immediate.
- alu_src_a  out  2  ALU operand A: 00 = PC, 01 = oldPC, 10 = rs1.
- alu_src_b  out  2  ALU operand B: 00 = rs2, 01 = immediate, 10 = constant 4.
- alu_ctrl  out  4  ALU operation code.
- instr_retired  out  1  one-cycle pulse on an instruction's final cycle.
- trap  out  1  controller halted.
- trap_cause  out  2  halt reason: 01 = illegal instruction, 10 = memory timeout.

Behaviour:
- States, 4-bit encoding: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, LUI, TRAP.
- Reset value of every output is 0; the FSM enters FETCH. Outputs are a pure decode of the state, plus mem_ready in the access states and the ALU flags in BRANCH. The watchdog counter resets to 0.
- FETCH:
  - Drives mem_req=1, iord=0, alu_src_a=00, alu_src_b=10, alu_ctrl=ADD.
  - If mem_ready=1 in the same cycle: ir_write=1, pc_write=1, pc_src=0, and the next state is DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE:
  - Computes the branch/JAL target: alu_src_a=01, alu_src_b=01, ADD, result held in ALUOut.
  - Next state by opcode:
    - 0000011 (load) or 0100011 (store) → MEM_ADDR.
    - 0110011 → EXEC_R.
    - 0010011 → EXEC_I.
    - 1100011 → BRANCH, but only if funct3 is not 010 or 011.
    - 1101111 → JAL.
    - 0110111 → LUI.
    - Anything else → TRAP with cause 01.
- MEM_ADDR: computes rs1 + imm with alu_src_a=10, alu_src_b=01, ADD. Next state is MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_req=1, iord=1. If mem_ready=1, the next state is MEM_WB.
- MEM_WB: reg_write=1, result_src=01, instr_retired=1. Next state is FETCH.
- MEM_WR: mem_req=1, mem_write=1, iord=1. If mem_ready=1: instr_retired=1 and the next state is FETCH.
- EXEC_R:
  - alu_src_a=10, alu_src_b=00.
  - alu_ctrl = {funct7[5], funct3}.
  - Next state is ALU_WB.
- EXEC_I:
  - alu_src_a=10, alu_src_b=01.
  - alu_ctrl = {funct7[5], funct3} when funct3 = 101; otherwise {0, funct3}.
  - Next state is ALU_WB.
- ALU_WB: reg_write=1, result_src=00, instr_retired=1. Next state is FETCH.
- alu_ctrl encoding:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011.
  - XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- BRANCH:
  - alu_src_a=10, alu_src_b=00, alu_ctrl=SUB.
  - taken is computed from funct3:
    - 000: zero; 001: !zero.
    - 100: lessSigend; 101: !lessSigend.
    - 110: lessUnsigend; 111: !lessUnsigend.
  - pc_write = taken, pc_src=1, instr_retired=1. Next state is FETCH.
- JAL: reg_write=1, result_src=10, pc_write=1, pc_src=1, instr_retired=1. Next state is FETCH.
- LUI: reg_write=1, result_src=11, instr_retired=1. Next state is FETCH.
- Watchdog:
  - The counter increments on each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - It clears on mem_ready=1 and on any state change.
  - When the counter reaches WAIT_MAX with mem_ready still 0, the next state is TRAP with cause 10, and mem_req drops on the following cycle.
  - mem_ready=1 in the same cycle the counter reaches WAIT_MAX counts as completion; no trap is raised.
- TRAP:
  - Absorbing state: trap=1 and trap_cause is held.
  - All enables (mem_req, pc_write, reg_write, ir_write) are 0.
  - Only reset exits TRAP.
- mem_ready while mem_req=0 is ignored.
- Reset asserted mid-access: mem_req goes low asynchronously and no enable pulses.
- Latency:
  - 3 cycles: ALU-free branch, JAL, LUI.
  - 4 cycles: R-type, I-type, store.
  - 5 cycles: load.
  - Each figure assumes zero memory wait states; every wait cycle adds one.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with mem_ready tied to 1:
  - Required state sequence FETCH, DECODE, EXEC_I, ALU_WB.
  - alu_ctrl=0000 in EXEC_I; reg_write=1 and instr_retired=1 in cycle 4.
- LW with mem_ready delayed 3 cycles in MEM_RD:
  - mem_req and iord stay 1 for 4 cycles.
  - MEM_WB is reached; reg_write=1 and result_src=01; 8 cycles in total.
- BNE with zero=1: pc_write=0 in BRANCH. BGEU with lessUnsigend=0: pc_write=1 and pc_src=1.
- SUB (funct7=0100000): alu_ctrl=1000. SRAI (funct7[5]=1, funct3=101): alu_ctrl=1101. XORI: alu_ctrl=0100.
- Illegal cases:
  - Opcode 0x0000007F: TRAP after DECODE, trap=1, trap_cause=01, and no further mem_req until reset.
  - Branch with funct3=010 gives the same result.
- mem_ready held 0 in MEM_WR with WAIT_MAX=4:
  - TRAP with cause 10 after 4 wait cycles.
  - Asserting reset mid-wait instead clears mem_req immediately and restarts in FETCH.
